// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the parity rule used by both RX and TX.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    localparam int unsigned PAR_W = 32;

    // typ=1 gives odd parity, typ=0 even; narrower data is zero-extended, which leaves the XOR unchanged
    function automatic logic parity_calc(input logic [PAR_W-1:0] data, input logic typ);
        return typ ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchroniser, per-bit edge/bit counters and bit-value sampling.
// Optional UART_RX_MAJORITY_EN: 3-sample majority vote, decided one clk after mid-bit.
module uart_rx_sampler #(
    parameter  int unsigned FRAME_WIDTH = 8,
    parameter  int unsigned PRESCALE    = 8,
    localparam int unsigned EW          = $clog2(PRESCALE),
    localparam int unsigned BW          = $clog2(FRAME_WIDTH + 3)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_rx,
    input  logic          i_en,
    output logic          o_rx_s,
    output logic          o_sample_bit,
    output logic          o_sample_stb,
    output logic          o_bit_done,
    output logic [BW-1:0] o_bit_cnt
);

    localparam logic [EW-1:0] MID  = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] LAST = EW'(PRESCALE - 1);

    logic [1:0]    r_sync;
    logic [EW-1:0] r_edge_cnt;
    logic [BW-1:0] r_bit_cnt;
    logic          w_rx_s;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end

    // Counters are held at zero while idle so the start bit always begins at edge 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (!i_en) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (r_edge_cnt == LAST) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
        end else begin
            r_edge_cnt <= r_edge_cnt + 1'b1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic r_s0;
    logic r_s1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else begin
            if (r_edge_cnt == MID - 1'b1) r_s0 <= w_rx_s;
            if (r_edge_cnt == MID)        r_s1 <= w_rx_s;
        end
    end

    assign o_sample_stb = i_en && (r_edge_cnt == MID + 1'b1);
    assign o_sample_bit = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
`else
    assign o_sample_stb = i_en && (r_edge_cnt == MID);
    assign o_sample_bit = w_rx_s;
`endif

    assign o_rx_s     = w_rx_s;
    assign o_bit_done = i_en && (r_edge_cnt == LAST);
    assign o_bit_cnt  = r_bit_cnt;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop FSM, shift register and error reporting.
// Build option UART_RX_MAJORITY_EN selects majority-vote bit sampling in uart_rx_sampler.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH = 8,
    parameter int unsigned PRESCALE    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   RX_IN,
    input  logic                   par_en,
    input  logic                   PAR_TYP,
    output logic [FRAME_WIDTH-1:0] P_Data,
    output logic                   Data_Valid,
    output logic                   par_err,
    output logic                   stp_err,
    output logic                   busy
);

    localparam int unsigned BW = $clog2(FRAME_WIDTH + 3);

    rx_state_t              r_state;
    rx_state_t              w_next;
    logic [FRAME_WIDTH-1:0] r_shadow;
    logic                   r_cfg_par_en;
    logic                   r_cfg_par_typ;
    logic                   r_par_flag;

    logic          w_en;
    logic          w_rx_s;
    logic          w_bit;
    logic          w_stb;
    logic          w_bit_done;
    logic [BW-1:0] w_bit_cnt;
    logic          w_start;
    logic          w_shift;
    logic          w_par_chk;
    logic          w_finish;
    logic          w_par_bad;
    logic          w_good;

    assign w_en = (r_state != IDLE);

    uart_rx_sampler #(
        .FRAME_WIDTH(FRAME_WIDTH),
        .PRESCALE   (PRESCALE)
    ) u_sampler (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_rx        (RX_IN),
        .i_en        (w_en),
        .o_rx_s      (w_rx_s),
        .o_sample_bit(w_bit),
        .o_sample_stb(w_stb),
        .o_bit_done  (w_bit_done),
        .o_bit_cnt   (w_bit_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Bit counter includes the start bit, so the last data bit wraps with count == FRAME_WIDTH
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_shift   = 1'b0;
        w_par_chk = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_next  = START;
                    w_start = 1'b1;
                end
            end
            START: begin
                if (w_stb && w_bit)   w_next = IDLE;
                else if (w_bit_done)  w_next = DATA;
            end
            DATA: begin
                w_shift = w_stb;
                if (w_bit_done && (w_bit_cnt == BW'(FRAME_WIDTH)))
                    w_next = r_cfg_par_en ? PARITY : STOP;
            end
            PARITY: begin
                w_par_chk = w_stb;
                if (w_bit_done) w_next = STOP;
            end
            STOP: begin
                if (w_stb) begin
                    w_next   = IDLE;
                    w_finish = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_par_bad = (w_bit != parity_calc(PAR_W'(r_shadow), r_cfg_par_typ));
    assign w_good    = w_finish && w_bit && !r_par_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            P_Data        <= '0;
            Data_Valid    <= 1'b0;
            par_err       <= 1'b0;
            stp_err       <= 1'b0;
            r_shadow      <= '0;
            r_cfg_par_en  <= 1'b0;
            r_cfg_par_typ <= 1'b0;
            r_par_flag    <= 1'b0;
        end else begin
            Data_Valid <= w_good;
            par_err    <= w_finish && r_par_flag;
            stp_err    <= w_finish && !w_bit;
            if (w_start) begin
                r_cfg_par_en  <= par_en;
                r_cfg_par_typ <= PAR_TYP;
                r_par_flag    <= 1'b0;
            end
            if (w_shift)               r_shadow   <= {w_bit, r_shadow[FRAME_WIDTH-1:1]};
            if (w_par_chk && w_par_bad) r_par_flag <= 1'b1;
            if (w_good)                P_Data     <= r_shadow;
        end
    end

    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames, glitch, back-to-back, reset abort, random frames.
module tb_uart_rx;

    localparam int unsigned FW = 8;
    localparam int unsigned PS = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          RX_IN;
    logic          par_en;
    logic          PAR_TYP;
    logic [FW-1:0] P_Data;
    logic          Data_Valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    always #5 clk = ~clk;

    uart_rx #(
        .FRAME_WIDTH(FW),
        .PRESCALE   (PS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .RX_IN     (RX_IN),
        .par_en    (par_en),
        .PAR_TYP   (PAR_TYP),
        .P_Data    (P_Data),
        .Data_Valid(Data_Valid),
        .par_err   (par_err),
        .stp_err   (stp_err),
        .busy      (busy)
    );

    int unsigned   tests = 0;
    int unsigned   fails = 0;
    int unsigned   cyc = 0;
    int unsigned   dv_cnt = 0;
    int unsigned   pe_cnt = 0;
    int unsigned   se_cnt = 0;
    int unsigned   dv_cyc[$];
    logic [FW-1:0] dv_data[$];
    logic [FW-1:0] exp_data;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            if (Data_Valid) begin
                dv_cnt++;
                dv_cyc.push_back(cyc);
                dv_data.push_back(P_Data);
            end
            if (par_err) pe_cnt++;
            if (stp_err) se_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        RX_IN = b;
        repeat (PS) @(posedge clk);
        #1;
    endtask

    // Serial frame on the line; optionally scrambles par_en/PAR_TYP once the start bit is over
    task automatic send(input logic [FW-1:0] d, input logic has_par, input logic pbit,
                        input logic sbit, input logic scramble);
        drive_bit(1'b0);
        if (scramble) begin
            par_en  = 1'($urandom_range(0, 1));
            PAR_TYP = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < int'(FW); i++) drive_bit(d[i]);
        if (has_par) drive_bit(pbit);
        drive_bit(sbit);
        RX_IN = 1'b1;
    endtask

    // Reference: a frame is good when stop is 1 and, with parity enabled, the total count of
    // ones (data + parity bit) is odd for PAR_TYP=1 or even for PAR_TYP=0
    task automatic frame(input string tag, input logic [FW-1:0] d, input logic pen,
                         input logic ptyp, input logic pbit, input logic sbit,
                         input logic scramble);
        int unsigned dv0, pe0, se0, ones;
        logic perr, serr, good;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        par_en  = pen;
        PAR_TYP = ptyp;
        send(d, pen, pbit, sbit, scramble);
        repeat (16) @(posedge clk);
        @(negedge clk);
        ones = $countones(d) + (pbit ? 1 : 0);
        perr = pen && (((ones % 2) == 1) != ptyp);
        serr = !sbit;
        good = !perr && !serr;
        if (good) exp_data = d;
        chk({tag, ".dv"},   dv_cnt - dv0, good ? 1 : 0);
        chk({tag, ".perr"}, pe_cnt - pe0, perr ? 1 : 0);
        chk({tag, ".serr"}, se_cnt - se0, serr ? 1 : 0);
        chk({tag, ".data"}, 32'(P_Data),  32'(exp_data));
    endtask

    initial begin
        int unsigned dv0, pe0, se0, n;
        logic [FW-1:0] d;
        logic pen, ptyp, pbit, sbit, good_par;

        reset = 1'b0; RX_IN = 1'b1; par_en = 1'b0; PAR_TYP = 1'b0;
        exp_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.outs", {P_Data, Data_Valid, par_err, stp_err, busy}, '0);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("idle.busy",  32'(busy), 0);
        chk("idle.pulse", dv_cnt + pe_cnt + se_cnt, 0);
        @(posedge clk); #1;

        frame("e2",     8'hE2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        frame("cc_ok",  8'hCC, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        frame("cc_par", 8'hCC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        frame("33_stp", 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        RX_IN = 1'b0;
        repeat (3) @(posedge clk);
        #1 RX_IN = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("glitch.busy_hi", 32'(busy), 1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("glitch.busy_lo", 32'(busy), 0);
        repeat (20) @(posedge clk);
        chk("glitch.pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
        #1;

        dv0 = dv_cnt;
        par_en = 1'b0;
        send(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (16) @(posedge clk);
        @(negedge clk);
        n = dv_cyc.size();
        chk("b2b.count", dv_cnt - dv0, 2);
        if (n >= 2) begin
            chk("b2b.gap",    dv_cyc[n-1] - dv_cyc[n-2], PS * 10);
            chk("b2b.first",  32'(dv_data[n-2]), 32'h A5);
            chk("b2b.second", 32'(dv_data[n-1]), 32'h 5A);
        end else begin
            chk("b2b.queue", n, 2);
        end
        @(posedge clk); #1;

        dv0 = dv_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[0] ^ 1'b1);
        reset = 1'b0;
        RX_IN = 1'b1;
        @(negedge clk);
        chk("abort.outs", {P_Data, Data_Valid, par_err, stp_err, busy}, '0);
        exp_data = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort.nopulse", dv_cnt - dv0, 0);
        frame("after_abort", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 24; k++) begin
            d    = 8'($urandom);
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            good_par = ptyp ? (($countones(d) % 2) == 0) : (($countones(d) % 2) == 1);
            pbit = good_par ^ ($urandom_range(0, 3) == 0);
            sbit = ($urandom_range(0, 4) != 0);
            frame("rand", d, pen, ptyp, pbit, sbit, 1'b1);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
